// File: rtl/overlay_fb_pkg.sv
// Shared types, palette and grid geometry helpers
// for the overlay frame buffer.
package overlay_fb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  localparam logic [23:0] PALETTE [4] = '{
    24'h000000,
    24'hFFFFFF,
    24'hFF00FF,
    24'h00FF00
  };

  // Indices above 3 wrap back onto 1..3.
  function automatic logic [23:0] palette_rgb(
    input int unsigned q
  );
    logic [1:0] idx;
    if (q == 0) begin
      idx = 2'd0;
    end else begin
      idx = 2'(((q - 1) % 3) + 1);
    end
    return PALETTE[idx];
  endfunction

  function automatic int grid_w(
    input int win_w,
    input int shift
  );
    return win_w >> shift;
  endfunction

  function automatic int grid_h(
    input int win_h,
    input int shift
  );
    return win_h >> shift;
  endfunction

  function automatic int depth(
    input int win_w,
    input int win_h,
    input int shift
  );
    return grid_w(win_w, shift) * grid_h(win_h, shift);
  endfunction

endpackage

// File: rtl/overlay_fb_if.sv
// Cell write port and clear control handshake
// between the renderer and the frame buffer.
interface overlay_fb_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 2
);

  logic                  WR_VALID;
  logic                  WR_READY;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  CLEAR_REQ;
  logic                  CLEAR_BUSY;

  modport master (
    output WR_VALID,
    output WR_ADDR,
    output WR_DATA,
    output CLEAR_REQ,
    input  WR_READY,
    input  CLEAR_BUSY
  );

  modport slave (
    input  WR_VALID,
    input  WR_ADDR,
    input  WR_DATA,
    input  CLEAR_REQ,
    output WR_READY,
    output CLEAR_BUSY
  );

endinterface

// File: rtl/overlay_fb_ram.sv
// Simple dual-port cell RAM: one write port and
// one registered read-first read port.
module overlay_fb_ram #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Both statements sample mem before the update,
  // so a same-address read returns the old cell.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/overlay_frame_buffer.sv
// Cell-grid overlay on the VGA RGB stream with a
// fixed three-stage read pipeline and clear engine.
module overlay_frame_buffer
  import overlay_fb_pkg::*;
#(
  parameter int X_START     = 144,
  parameter int Y_START     = 35,
  parameter int WIN_W       = 640,
  parameter int WIN_H       = 480,
  parameter int SCALE_SHIFT = 3,
  parameter int DATA_WIDTH  = 2,
  parameter int ADDR_WIDTH  = 13
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  VGA_R_IN,
  input  logic [7:0]  VGA_G_IN,
  input  logic [7:0]  VGA_B_IN,
  input  logic [12:0] H_CNT,
  input  logic [12:0] V_CNT,
  overlay_fb_if.slave wr,
  output logic [7:0]  VGA_R_OUT,
  output logic [7:0]  VGA_G_OUT,
  output logic [7:0]  VGA_B_OUT
);

  localparam int GRID_W = grid_w(WIN_W, SCALE_SHIFT);
  localparam int DEPTH =
    depth(WIN_W, WIN_H, SCALE_SHIFT);

  localparam logic signed [13:0] XS = 14'(X_START);
  localparam logic signed [13:0] YS = 14'(Y_START);
  localparam logic signed [13:0] WW = 14'(WIN_W);
  localparam logic signed [13:0] WH = 14'(WIN_H);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_V =
    (ADDR_WIDTH + 1)'(DEPTH);

  logic signed [13:0]    dx;
  logic signed [13:0]    dy;
  logic [13:0]           cx;
  logic [13:0]           cy;
  logic                  in_win;
  logic [ADDR_WIDTH-1:0] lin;

  assign dx = $signed({1'b0, H_CNT}) - XS;
  assign dy = $signed({1'b0, V_CNT}) - YS;
  assign in_win = !dx[13] && (dx < WW) &&
                  !dy[13] && (dy < WH);
  assign cx = $unsigned(dx) >> SCALE_SHIFT;
  assign cy = $unsigned(dy) >> SCALE_SHIFT;
  assign lin = ADDR_WIDTH'(cy * GRID_W + cx);

  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  s1_win;
  logic [23:0]           s1_rgb;
  logic                  s2_win;
  logic [23:0]           s2_rgb;
  logic [DATA_WIDTH-1:0] q;
  logic [23:0]           rgb_out;

  // RGB delay runs through reset so pass-through
  // is valid as soon as reset drops.
  always_ff @(posedge CLK) begin
    s1_rgb  <= {VGA_R_IN, VGA_G_IN, VGA_B_IN};
    s2_rgb  <= s1_rgb;
    s1_addr <= in_win ? lin : '0;
    if (RESET) begin
      s1_win  <= 1'b0;
      s2_win  <= 1'b0;
      rgb_out <= '0;
    end else begin
      s1_win  <= in_win;
      s2_win  <= s1_win;
      if (s2_win && (q != '0)) begin
        rgb_out <= palette_rgb(32'(q));
      end else begin
        rgb_out <= s2_rgb;
      end
    end
  end

  assign VGA_R_OUT = rgb_out[23:16];
  assign VGA_G_OUT = rgb_out[15:8];
  assign VGA_B_OUT = rgb_out[7:0];

  fb_state_t             state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  busy;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr.CLEAR_REQ) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr.CLEAR_BUSY = busy;
  assign wr.WR_READY   = !busy && !RESET;

  logic                  clr_we;
  logic                  wr_we;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // Out-of-range writes complete the handshake
  // but never reach the array.
  assign clr_we = (state == CLEAR) && !RESET;
  assign wr_we  = wr.WR_VALID && wr.WR_READY &&
                  ({1'b0, wr.WR_ADDR} < DEPTH_V);
  assign ram_we    = clr_we || wr_we;
  assign ram_waddr = clr_we ? cnt : wr.WR_ADDR;
  assign ram_wdata = clr_we ? '0 : wr.WR_DATA;

  overlay_fb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr),
    .rdata (q)
  );

endmodule

// File: tb/tb_overlay_frame_buffer.sv
// Directed bench for overlay_frame_buffer with
// default 640x480 window and 8x8 cells.
module tb_overlay_frame_buffer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  VGA_R_IN, VGA_G_IN, VGA_B_IN;
  logic [12:0] H_CNT, V_CNT;
  logic [7:0]  VGA_R_OUT, VGA_G_OUT, VGA_B_OUT;
  logic [23:0] out_rgb;

  overlay_fb_if #(.ADDR_WIDTH(13), .DATA_WIDTH(2)) wr();

  overlay_frame_buffer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .VGA_R_IN  (VGA_R_IN),
    .VGA_G_IN  (VGA_G_IN),
    .VGA_B_IN  (VGA_B_IN),
    .H_CNT     (H_CNT),
    .V_CNT     (V_CNT),
    .wr        (wr),
    .VGA_R_OUT (VGA_R_OUT),
    .VGA_G_OUT (VGA_G_OUT),
    .VGA_B_OUT (VGA_B_OUT)
  );

  always #5 CLK = ~CLK;
  assign out_rgb = {VGA_R_OUT, VGA_G_OUT, VGA_B_OUT};

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0]  model [0:4799];
  logic [23:0] expq [$];
  localparam logic [23:0] PASS = 24'h123456;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_px(int h, int v, logic [23:0] rgb);
    H_CNT = 13'(h);
    V_CNT = 13'(v);
    {VGA_R_IN, VGA_G_IN, VGA_B_IN} = rgb;
  endtask

  function automatic logic [23:0] pal(logic [1:0] c);
    case (c)
      2'd1:    return 24'hFFFFFF;
      2'd2:    return 24'hFF00FF;
      2'd3:    return 24'h00FF00;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_px(
    int h, int v, logic [23:0] rgb);
    logic [1:0] c;
    c = 2'd0;
    if (h >= 144 && h < 784 && v >= 35 && v < 515)
      c = model[((v - 35) >> 3) * 80 + ((h - 144) >> 3)];
    return (c != 2'd0) ? pal(c) : rgb;
  endfunction

  task automatic stream_px(int h, int v,
    logic [23:0] rgb, string name);
    logic [23:0] e;
    drive_px(h, v, rgb);
    expq.push_back(model_px(h, v, rgb));
    tick();
    if (expq.size() == 3) begin
      e = expq.pop_front();
      n_cmp++;
      if (out_rgb !== e) begin
        n_bad++;
        $display("FAIL %s h=%0d v=%0d: got %h want %h",
                 name, h, v, out_rgb, e);
      end
    end
  endtask

  task automatic flush(string name);
    stream_px(0, 0, 24'h000001, name);
    stream_px(0, 0, 24'h000002, name);
    expq.delete();
  endtask

  task automatic hold_px(int h, int v,
    logic [23:0] e, string name);
    drive_px(h, v, PASS);
    repeat (3) tick();
    n_cmp++;
    if (out_rgb !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               name, out_rgb, e);
    end
  endtask

  task automatic write_cell(int a, logic [1:0] d);
    wr.WR_VALID = 1'b1;
    wr.WR_ADDR  = 13'(a);
    wr.WR_DATA  = d;
    #1;
    n_cmp++;
    if (wr.WR_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_ready addr %0d: got %b want 1",
               a, wr.WR_READY);
    end
    tick();
    wr.WR_VALID = 1'b0;
    if (a < 4800) model[a] = d;
  endtask

  task automatic sweep_cells(string name);
    for (int cy = 0; cy < 60; cy++)
      for (int cx = 0; cx < 80; cx++)
        stream_px(144 + 8 * cx + (cx + cy) % 8,
                  35 + 8 * cy + (cx * 3 + cy) % 8,
                  {8'(cx), 8'(cy), 8'hA5}, name);
    flush(name);
  endtask

  // Samples CLEAR_BUSY after each edge; optional
  // repeat request at busy cycle 100.
  task automatic run_clear(bit repulse,
    output int cycles, output int ready_bad);
    cycles = 0;
    ready_bad = 0;
    tick();
    wr.CLEAR_REQ = 1'b0;
    while (wr.CLEAR_BUSY === 1'b1 && cycles < 10000) begin
      cycles++;
      if (wr.WR_READY !== 1'b0) ready_bad++;
      wr.CLEAR_REQ = repulse && (cycles == 100);
      tick();
    end
    wr.CLEAR_REQ = 1'b0;
    for (int i = 0; i < 4800; i++) model[i] = 2'd0;
  endtask

  task automatic check_clear(int cycles, int ready_bad,
    string name);
    n_cmp++;
    if (cycles != 4800) begin
      n_bad++;
      $display("FAIL %s busy_len: got %0d want 4800",
               name, cycles);
    end
    n_cmp++;
    if (ready_bad != 0) begin
      n_bad++;
      $display("FAIL %s ready_low: got %0d high want 0",
               name, ready_bad);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    drive_px(200, 100, PASS);
    repeat (3) tick();
    n_cmp++;
    if (out_rgb !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 000000", out_rgb);
    end
    n_cmp++;
    if (wr.CLEAR_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b want 0", wr.CLEAR_BUSY);
    end
    n_cmp++;
    if (wr.WR_READY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", wr.WR_READY);
    end
    RESET = 1'b0;
    tick();
    n_cmp++;
    if (wr.WR_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b want 1",
               wr.WR_READY);
    end
  endtask

  task automatic test_initial_clear();
    int cyc, rb;
    wr.CLEAR_REQ = 1'b1;
    run_clear(1'b0, cyc, rb);
    check_clear(cyc, rb, "init_clear");
  endtask

  task automatic test_passthrough();
    int rows [5] = '{0, 34, 35, 514, 515};
    for (int r = 0; r < 5; r++)
      for (int h = 130; h <= 800; h++)
        stream_px(h, rows[r],
                  {8'(h), 8'(rows[r]), 8'(h ^ rows[r])},
                  "passthru_row");
    flush("passthru_row");
    sweep_cells("passthru_cells");
  endtask

  task automatic test_single_cell();
    write_cell(0, 2'd2);
    hold_px(144, 35, 24'hFF00FF, "cell0_first");
    hold_px(151, 42, 24'hFF00FF, "cell0_last");
    hold_px(152, 35, PASS, "h152_pass");
    hold_px(143, 35, PASS, "h143_pass");
    for (int h = 138; h <= 160; h++)
      stream_px(h, 35, {8'(h), 8'h11, 8'h22}, "row35");
    flush("row35");
  endtask

  task automatic test_last_cell();
    write_cell(4799, 2'd1);
    hold_px(783, 514, 24'hFFFFFF, "last_cell");
    hold_px(784, 514, PASS, "h784_pass");
    hold_px(783, 515, PASS, "v515_pass");
    write_cell(4800, 2'd3);
    sweep_cells("oor_write");
  endtask

  task automatic test_clear_handshake();
    int cyc, rb;
    write_cell(0, 2'd3);
    write_cell(100, 2'd3);
    write_cell(4799, 2'd3);
    hold_px(304, 43, 24'h00FF00, "cell100");
    wr.WR_VALID  = 1'b1;
    wr.WR_ADDR   = 13'd5;
    wr.WR_DATA   = 2'd1;
    wr.CLEAR_REQ = 1'b1;
    #1;
    n_cmp++;
    if (wr.WR_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_with_req: got %b want 1",
               wr.WR_READY);
    end
    @(posedge CLK);
    wr.WR_VALID = 1'b0;
    #1;
    n_cmp++;
    if (wr.CLEAR_BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_start: got %b want 1",
               wr.CLEAR_BUSY);
    end
    wr.CLEAR_REQ = 1'b0;
    cyc = 0;
    rb = 0;
    while (wr.CLEAR_BUSY === 1'b1 && cyc < 10000) begin
      cyc++;
      if (wr.WR_READY !== 1'b0) rb++;
      wr.CLEAR_REQ = (cyc == 100);
      tick();
    end
    wr.CLEAR_REQ = 1'b0;
    for (int i = 0; i < 4800; i++) model[i] = 2'd0;
    check_clear(cyc, rb, "clear_hs");
    sweep_cells("after_clear");
  endtask

  task automatic test_collision();
    write_cell(0, 2'd2);
    drive_px(144, 35, PASS);
    tick();
    drive_px(0, 0, PASS);
    wr.WR_VALID = 1'b1;
    wr.WR_ADDR  = 13'd0;
    wr.WR_DATA  = 2'd1;
    tick();
    wr.WR_VALID = 1'b0;
    tick();
    n_cmp++;
    if (out_rgb !== 24'hFF00FF) begin
      n_bad++;
      $display("FAIL collision_old: got %h want ff00ff",
               out_rgb);
    end
    model[0] = 2'd1;
    hold_px(144, 35, 24'hFFFFFF, "collision_new");
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 10; i++) write_cell(i, 2'd1);
    write_cell(4799, 2'd3);
    drive_px(200, 100, PASS);
    wr.CLEAR_REQ = 1'b1;
    tick();
    wr.CLEAR_REQ = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (wr.CLEAR_BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_mid: got %b want 1", wr.CLEAR_BUSY);
    end
    RESET = 1'b1;
    tick();
    n_cmp++;
    if (wr.CLEAR_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got %b want 0",
               wr.CLEAR_BUSY);
    end
    n_cmp++;
    if (out_rgb !== 24'h0) begin
      n_bad++;
      $display("FAIL abort_out: got %h want 000000", out_rgb);
    end
    RESET = 1'b0;
    tick();
    for (int k = 0; k < 10; k++)
      hold_px(144 + 8 * k, 35, PASS, "cleared_cell");
    hold_px(783, 514, 24'h00FF00, "kept_cell");
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1);
  end

  initial begin
    RESET        = 1'b1;
    wr.WR_VALID  = 1'b0;
    wr.WR_ADDR   = '0;
    wr.WR_DATA   = '0;
    wr.CLEAR_REQ = 1'b0;
    drive_px(0, 0, 24'h0);
    for (int i = 0; i < 4800; i++) model[i] = 2'd0;
    test_reset();
    test_initial_clear();
    test_passthrough();
    test_single_cell();
    test_last_cell();
    test_clear_handshake();
    test_collision();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/overlay_frame_buffer.md
Name: overlay_frame_buffer

Overview:
Parametrised single-clock overlay frame buffer for the VGA pipeline. It stores a coarse grid of cells (DATA_WIDTH bits each) covering a configurable window. Each cell is replicated over a 2^SCALE_SHIFT square of pixels. The block colours active pixels through a fixed palette over the incoming RGB stream. Compared with the previous generation, it adds parametrised geometry and width, transparent value 0, a valid/ready write port, a hardware clear engine and a fixed pipeline latency with aligned pass-through RGB. It sits between the pattern/game renderer and the VGA DAC output stage.

Parameters:
X_START, 144, H_CNT value of first visible window column
Y_START, 35, V_CNT value of first visible window row
WIN_W, 640, window width in pixels (multiple of 2^SCALE_SHIFT)
WIN_H, 480, window height in pixels (multiple of 2^SCALE_SHIFT)
SCALE_SHIFT, 3, log2 of cell edge in pixels (3 -> 8x8 cells, grid 80x60)
DATA_WIDTH, 2, bits per cell; value 0 is transparent
ADDR_WIDTH, 13, cell address width; must satisfy 2^ADDR_WIDTH >= DEPTH

Ports:
CLK  in  1  pixel clock; sole clock
RESET  in  1  synchronous, active-high reset
VGA_R_IN  in  8  incoming red
VGA_G_IN  in  8  incoming green
VGA_B_IN  in  8  incoming blue
H_CNT  in  13  horizontal counter for the current pixel
V_CNT  in  13  vertical counter for the current pixel
WR_VALID  in  1  write request
WR_READY  out  1  write can be accepted this cycle
WR_ADDR  in  ADDR_WIDTH  cell address, row-major (cy*GRID_W + cx)
WR_DATA  in  DATA_WIDTH  cell value
CLEAR_REQ  in  1  single-cycle pulse: zero all cells
CLEAR_BUSY  out  1  clear in progress
VGA_R_OUT  out  8  overlaid red
VGA_G_OUT  out  8  overlaid green
VGA_B_OUT  out  8  overlaid blue

Behaviour:
- Derived values: GRID_W = WIN_W>>SCALE_SHIFT, GRID_H = WIN_H>>SCALE_SHIFT, DEPTH = GRID_W*GRID_H.
- Read pipeline has a fixed latency of 3 cycles from H_CNT/V_CNT/RGB_IN to RGB_OUT. It runs every cycle and never stalls.
  - S1: in_win = X_START <= H_CNT < X_START+WIN_W and Y_START <= V_CNT < Y_START+WIN_H. cx = (H_CNT-X_START)>>SCALE_SHIFT, cy = (V_CNT-Y_START)>>SCALE_SHIFT. Register address, in_win and RGB.
  - S2: registered RAM read. in_win and RGB are delayed in step with it.
  - S3: if in_win and q != 0, output PALETTE[q]; otherwise output the delayed RGB_IN. All outputs are registered.
- Subtractions are computed at 14 bits signed. No wrap: pixels outside the window never address RAM (address forced to 0, in_win = 0).
- Write port:
  - WR_READY = !CLEAR_BUSY && !RESET.
  - A write is accepted on the cycle where WR_VALID && WR_READY.
  - If WR_ADDR >= DEPTH, the write is accepted but dropped (RAM is not modified).
- Read and write to the same address in the same cycle: the read returns the old data (read-first).
- Clear FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR on CLEAR_REQ. The counter is loaded with 0.
  - In CLEAR, the block writes 0 to the counter address each cycle and increments the counter. It returns to IDLE after address DEPTH-1 is written, so CLEAR_BUSY is high for exactly DEPTH cycles.
  - CLEAR_REQ during CLEAR is ignored.
  - CLEAR_REQ together with WR_VALID in IDLE: the write is accepted that cycle (READY is still 1), then the clear starts on the next cycle.
- Reset values: VGA_*_OUT = 0, CLEAR_BUSY = 0, FSM = IDLE, pipeline in_win flags = 0.
  - RAM contents are not reset.
  - Reset during CLEAR aborts the clear immediately and leaves the cells partially cleared.
  - For 3 cycles after reset the outputs carry the delayed pass-through RGB (in_win flushed to 0).
- PALETTE: 1 = white (FF,FF,FF), 2 = magenta (FF,00,FF), 3 = green (00,FF,00). For DATA_WIDTH > 2, higher indices repeat the palette modulo 3 (index 0 excluded).

Decomposition:
- Package overlay_fb_pkg holds:
  - fb_state_t enum (IDLE, CLEAR);
  - the PALETTE constant array and the palette lookup function;
  - the grid_w/grid_h/depth functions of the geometry parameters.
- Sub-module overlay_fb_ram: single-clock simple dual-port RAM with one write port and one registered read-first read port, parametrised by DATA_WIDTH and ADDR_WIDTH. The clear engine and the write port are muxed onto its single write port; the clear has priority.

Test Plan:
- Pixel pass-through: defaults; all cells 0 after a clear; sweep a full frame -> RGB_OUT equals RGB_IN delayed exactly 3 cycles everywhere.
- Single cell: write addr 0 = 2; pixel (H_CNT 144..151, V_CNT 35..42) -> FF,00,FF. Pixel H_CNT 152 -> pass-through. Pixel H_CNT 143 -> pass-through.
- Last cell and out-of-range address:
  - write addr 4799 = 1 -> pixel (H 783, V 514) is white;
  - write addr 4800 = 3 with WR_READY = 1 -> no visible change anywhere.
- Clear and handshake: write cells 0, 100, 4799 = 3, then pulse CLEAR_REQ.
  - CLEAR_BUSY is high for exactly 4800 cycles and WR_READY is low throughout.
  - A CLEAR_REQ issued mid-clear does not extend the clear.
  - Afterwards all cells read transparent.
- Read/write collision: write addr 0 = 1 on the same cycle the S1 address for pixel (144,35) is 0, with the old value 2 -> that pixel shows magenta; the next frame shows white.
- Reset mid-clear: assert RESET at clear cycle 10 -> CLEAR_BUSY = 0 and outputs = 0 on the next cycle. Cells 0..9 are 0 and cell 4799 keeps its pre-clear value 3.
